// File: rtl/if_id_queue_if.sv
// IF/ID queue bus: fetch-side handshake, pipeline controls and the ID-facing register outputs.
interface if_id_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             EN;
    logic             Data_stall;
    logic             flush;
    logic             if_valid;
    logic [XLEN-1:0]  PCOUT;
    logic [ILEN-1:0]  IR;
    logic             if_ready;
    logic [ILEN-1:0]  IR_ID;
    logic [XLEN-1:0]  PCurrent_ID;
    logic             valid_ID;
    logic [CNT_W-1:0] count;

    modport master (
        output EN, Data_stall, flush, if_valid, PCOUT, IR,
        input  if_ready, IR_ID, PCurrent_ID, valid_ID, count
    );

    modport slave (
        input  EN, Data_stall, flush, if_valid, PCOUT, IR,
        output if_ready, IR_ID, PCurrent_ID, valid_ID, count
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID pipeline stage: DEPTH-entry instruction queue feeding a registered ID output,
// with an empty-queue bypass so IF->ID latency stays one cycle when nothing is queued.
module if_id_queue #(
    parameter int unsigned     XLEN   = 32,
    parameter int unsigned     ILEN   = 32,
    parameter int unsigned     DEPTH  = 2,
    parameter logic [ILEN-1:0] NOP    = ILEN'(32'h0000_0013),
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input logic          clk,
    input logic          rst,
    if_id_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [ILEN-1:0] ir_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];

    ptr_t            wr_ptr;
    ptr_t            rd_ptr;
    cnt_t            cnt;
    logic [ILEN-1:0] ir_id;
    logic [XLEN-1:0] pc_id;
    logic            valid_id;

    logic full;
    logic empty;
    logic ready;
    logic acc;
    logic adv;
    logic rd_en;
    logic byp;
    logic wr_en;

    always_comb begin
        full  = (cnt == cnt_t'(DEPTH));
        empty = (cnt == '0);
        ready = bus.EN & ~bus.flush & ~full;
        acc   = bus.if_valid & ready;
        adv   = bus.EN & ~bus.Data_stall & ~bus.flush;
        rd_en = adv & ~empty;
        // An empty queue hands the fetched word straight to the output register.
        byp   = adv & empty & acc;
        wr_en = acc & ~byp;
    end

    // Storage carries no reset; occupancy is tracked solely by cnt and the pointers.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            ir_mem[wr_ptr] <= bus.IR;
            pc_mem[wr_ptr] <= bus.PCOUT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.EN) begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + ptr_t'(1);
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + ptr_t'(1);
                end
                case ({wr_en, rd_en})
                    2'b10:   cnt <= cnt + cnt_t'(1);
                    2'b01:   cnt <= cnt - cnt_t'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Stall has priority over flush for the output register; the queue is cleared regardless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_id    <= NOP;
            pc_id    <= RST_PC;
            valid_id <= 1'b0;
        end else if (bus.EN && !bus.Data_stall) begin
            if (bus.flush) begin
                ir_id    <= NOP;
                valid_id <= 1'b0;
            end else if (rd_en) begin
                ir_id    <= ir_mem[rd_ptr];
                pc_id    <= pc_mem[rd_ptr];
                valid_id <= 1'b1;
            end else if (byp) begin
                ir_id    <= bus.IR;
                pc_id    <= bus.PCOUT;
                valid_id <= 1'b1;
            end else begin
                ir_id    <= NOP;
                valid_id <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.if_ready    = ready;
        bus.IR_ID       = ir_id;
        bus.PCurrent_ID = pc_id;
        bus.valid_ID    = valid_id;
        bus.count       = cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (cnt <= cnt_t'(DEPTH));
            assert (!(wr_en && full));
            assert (!(rd_en && empty));
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: DEPTH=2 and DEPTH=4 instances, scoreboard-checked ID output.
module tb_if_id_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_id_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(2)) b2 ();
    if_id_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(4)) b4 ();

    if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(2), .NOP(NOP), .RST_PC(32'h0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(4), .NOP(NOP), .RST_PC(32'h0)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] sb2 [$];
    logic [63:0] sb4 [$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic idle();
        b2.EN = 1'b0; b2.Data_stall = 1'b0; b2.flush = 1'b0; b2.if_valid = 1'b0;
        b2.PCOUT = '0; b2.IR = '0;
        b4.EN = 1'b0; b4.Data_stall = 1'b0; b4.flush = 1'b0; b4.if_valid = 1'b0;
        b4.PCOUT = '0; b4.IR = '0;
    endtask

    // One cycle on the selected instance; the other is held with EN=0.
    task automatic apply(input bit sel, input logic en, input logic st, input logic fl,
                         input logic v, input logic [31:0] pc, input logic [31:0] ir,
                         input logic rdy, input int cnt, input string nm);
        @(negedge clk);
        idle();
        if (!sel) begin
            b2.EN = en; b2.Data_stall = st; b2.flush = fl; b2.if_valid = v;
            b2.PCOUT = pc; b2.IR = ir;
        end else begin
            b4.EN = en; b4.Data_stall = st; b4.flush = fl; b4.if_valid = v;
            b4.PCOUT = pc; b4.IR = ir;
        end
        #1;
        if (!sel) begin
            chk({nm, "_rdy"}, 64'(b2.if_ready), 64'(rdy));
            if (en && fl) sb2.delete();
            if (v && rdy) sb2.push_back({pc, ir});
        end else begin
            chk({nm, "_rdy"}, 64'(b4.if_ready), 64'(rdy));
            if (en && fl) sb4.delete();
            if (v && rdy) sb4.push_back({pc, ir});
        end
        @(posedge clk);
        #2;
        if (!sel) chk({nm, "_cnt"}, 64'(b2.count), 64'(cnt));
        else      chk({nm, "_cnt"}, 64'(b4.count), 64'(cnt));
    endtask

    logic [31:0] e2_ir = NOP;
    logic [31:0] e2_pc = '0;
    logic        e2_v  = 1'b0;
    logic [31:0] e4_ir = NOP;
    logic [31:0] e4_pc = '0;
    logic        e4_v  = 1'b0;

    always begin : mon2
        logic adv;
        logic fl_only;
        @(posedge clk);
        adv     = b2.EN & ~b2.Data_stall & ~b2.flush;
        fl_only = b2.EN & ~b2.Data_stall & b2.flush;
        #1;
        if (!rst) begin
            e2_ir = NOP; e2_pc = '0; e2_v = 1'b0;
        end else if (adv) begin
            if (sb2.size() > 0) begin
                {e2_pc, e2_ir} = sb2.pop_front();
                e2_v = 1'b1;
            end else begin
                e2_ir = NOP; e2_v = 1'b0;
            end
        end else if (fl_only) begin
            e2_ir = NOP; e2_v = 1'b0;
        end
        chk("d2_ir",    64'(b2.IR_ID),       64'(e2_ir));
        chk("d2_pc",    64'(b2.PCurrent_ID), 64'(e2_pc));
        chk("d2_valid", 64'(b2.valid_ID),    64'(e2_v));
    end

    always begin : mon4
        logic adv;
        logic fl_only;
        @(posedge clk);
        adv     = b4.EN & ~b4.Data_stall & ~b4.flush;
        fl_only = b4.EN & ~b4.Data_stall & b4.flush;
        #1;
        if (!rst) begin
            e4_ir = NOP; e4_pc = '0; e4_v = 1'b0;
        end else if (adv) begin
            if (sb4.size() > 0) begin
                {e4_pc, e4_ir} = sb4.pop_front();
                e4_v = 1'b1;
            end else begin
                e4_ir = NOP; e4_v = 1'b0;
            end
        end else if (fl_only) begin
            e4_ir = NOP; e4_v = 1'b0;
        end
        chk("d4_ir",    64'(b4.IR_ID),       64'(e4_ir));
        chk("d4_pc",    64'(b4.PCurrent_ID), 64'(e4_pc));
        chk("d4_valid", 64'(b4.valid_ID),    64'(e4_v));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ir",  64'(b2.IR_ID),       64'(NOP));
        chk("rst_pc",  64'(b2.PCurrent_ID), 64'h0);
        chk("rst_v",   64'(b2.valid_ID),    64'h0);
        chk("rst_cnt", 64'(b2.count),       64'h0);
        @(negedge clk);
        rst = 1'b1;

        // sel  en  st  fl  v   pc      ir            rdy cnt
        apply(0, 1, 0, 0, 1, 32'h00, 32'h00500093, 1, 0, "byp0");
        apply(0, 1, 0, 0, 1, 32'h04, 32'h00100113, 1, 0, "byp4");
        apply(0, 1, 0, 0, 1, 32'h08, 32'h002081b3, 1, 0, "byp8");
        apply(0, 1, 0, 0, 0, 32'h00, 32'h00000000, 1, 0, "bubble");

        apply(0, 1, 1, 0, 1, 32'h10, 32'h00a00213, 1, 1, "stl10");
        apply(0, 1, 1, 0, 1, 32'h14, 32'h00b00293, 1, 2, "stl14");
        apply(0, 1, 1, 0, 1, 32'h18, 32'h00c00313, 0, 2, "stl18a");
        apply(0, 1, 1, 0, 1, 32'h18, 32'h00c00313, 0, 2, "stl18b");
        apply(0, 1, 0, 0, 1, 32'h18, 32'h00c00313, 0, 1, "fullrd");
        apply(0, 1, 0, 0, 1, 32'h18, 32'h00c00313, 1, 1, "wr_rd");
        apply(0, 1, 0, 0, 0, 32'h00, 32'h00000000, 1, 0, "drain");
        apply(0, 1, 0, 0, 0, 32'h00, 32'h00000000, 1, 0, "empty");

        apply(0, 1, 0, 0, 1, 32'h1c, 32'h00d00393, 1, 0, "byp1c");
        apply(0, 1, 1, 0, 1, 32'h20, 32'h00e00413, 1, 1, "fil20");
        apply(0, 1, 1, 0, 1, 32'h24, 32'h00f00493, 1, 2, "fil24");
        apply(0, 1, 0, 1, 1, 32'h28, 32'h01000513, 0, 0, "flush");
        apply(0, 1, 0, 0, 1, 32'h40, 32'h01100593, 1, 0, "byp40");

        apply(0, 1, 1, 0, 1, 32'h44, 32'h01200613, 1, 1, "fil44");
        apply(0, 1, 1, 0, 1, 32'h48, 32'h01300693, 1, 2, "fil48");
        apply(0, 1, 1, 1, 1, 32'h4c, 32'h01400713, 0, 0, "flstl");
        apply(0, 1, 0, 0, 0, 32'h00, 32'h00000000, 1, 0, "postfl");

        apply(0, 1, 1, 0, 1, 32'h50, 32'h01500793, 1, 1, "fil50");
        apply(0, 1, 1, 0, 1, 32'h54, 32'h01600813, 1, 2, "fil54");
        @(negedge clk);
        idle();
        rst = 1'b0;
        sb2.delete();
        sb4.delete();
        #1;
        chk("mrst_ir",  64'(b2.IR_ID),       64'(NOP));
        chk("mrst_pc",  64'(b2.PCurrent_ID), 64'h0);
        chk("mrst_v",   64'(b2.valid_ID),    64'h0);
        chk("mrst_cnt", 64'(b2.count),       64'h0);
        @(negedge clk);
        rst = 1'b1;
        apply(0, 1, 0, 0, 1, 32'h00, 32'h00500093, 1, 0, "first");
        apply(0, 1, 0, 0, 0, 32'h00, 32'h00000000, 1, 0, "idle2");

        apply(1, 1, 1, 0, 1, 32'h100, 32'h10000013, 1, 1, "p100");
        apply(1, 1, 1, 0, 1, 32'h104, 32'h10400013, 1, 2, "p104");
        apply(1, 1, 1, 0, 1, 32'h108, 32'h10800013, 1, 3, "p108");
        apply(1, 1, 1, 0, 1, 32'h10c, 32'h10c00013, 1, 4, "p10c");
        apply(1, 1, 1, 0, 1, 32'h110, 32'h11000013, 0, 4, "full4");
        apply(1, 1, 0, 0, 1, 32'h110, 32'h11000013, 0, 3, "full4rd");
        apply(1, 1, 0, 0, 1, 32'h110, 32'h11000013, 1, 3, "wrap110");
        apply(1, 1, 0, 0, 1, 32'h114, 32'h11400013, 1, 3, "wrap114");
        apply(1, 1, 1, 0, 0, 32'h000, 32'h00000000, 1, 3, "hold4");
        apply(1, 0, 0, 0, 1, 32'h200, 32'h20000013, 0, 3, "en0a");
        apply(1, 0, 1, 1, 1, 32'h204, 32'h20400013, 0, 3, "en0b");
        apply(1, 0, 0, 1, 0, 32'h208, 32'h20800013, 0, 3, "en0c");
        apply(1, 1, 0, 0, 0, 32'h000, 32'h00000000, 1, 2, "dr10c");
        apply(1, 1, 0, 0, 0, 32'h000, 32'h00000000, 1, 1, "dr110");
        apply(1, 1, 0, 0, 0, 32'h000, 32'h00000000, 1, 0, "dr114");
        apply(1, 1, 0, 0, 0, 32'h000, 32'h00000000, 1, 0, "dr_nop");

        @(negedge clk);
        idle();
        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
